pipeline_hazard_ctrl: RTL and testbench

- Parametrised pipeline control for the 5-stage RV32I core.
- Owns the global advance signal, split instruction/data memory handshakes, load-use bubbles, branch/jump flushes, PC mux select, EX forwarding selects and perf counters.
- Sits between the IF/ID/EX/MEM/WB buffers and both cache ports.
- Memory responses may arrive in different cycles; each one is latched until the pipeline advances.

---
 rtl/pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the 5-stage RV32I core: memory handshakes, advance, hazards, flushes, perf counters.
// Define PIPE_FWD_EN to build EX-stage forwarding; without it every RAW hazard against EX/MEM stalls.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_resp,
    output logic                  imem_read,
    input  logic                  dmem_req,
    input  logic                  dmem_resp,
    output logic                  dmem_go,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  ex_regwrite,
    input  logic                  mem_regwrite,
    input  logic                  wb_regwrite,
    input  logic                  ex_is_load,
    input  logic                  ex_redirect,
    input  logic                  ex_jalr,
    output logic                  advance,
    output logic                  pc_hold,
    output logic                  ifid_hold,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic [1:0]            pc_sel,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [PERF_W-1:0]     stall_cnt,
    output logic [PERF_W-1:0]     flush_cnt
);

    typedef enum logic {I_WAIT = 1'b0, I_DONE = 1'b1} i_state_e;
    typedef enum logic [1:0] {D_IDLE = 2'd0, D_WAIT = 2'd1, D_DONE = 2'd2} d_state_e;

    i_state_e          i_state_q, i_state_d;
    d_state_e          d_state_q, d_state_d;
    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] flush_q, flush_d;

    logic imem_ok, dmem_ok, adv;
    logic redirect, load_use, bubble;
    logic ex_wr_nz, mem_wr_nz, id_hits_ex;

`ifdef PIPE_FWD_EN
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  mem_v,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  wb_v,
        input logic [REG_ADDR_W-1:0] w_rd
    );
        if (mem_v && (m_rd == rs)) return 2'd1;
        if (wb_v && (w_rd == rs)) return 2'd2;
        return 2'd0;
    endfunction
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, wb_rd, wb_regwrite};
`endif

    // Hazard detection and the combinational advance decision
    always_comb begin
        ex_wr_nz   = ex_regwrite && (ex_rd != '0);
        mem_wr_nz  = mem_regwrite && (mem_rd != '0);
        id_hits_ex = (id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd));
        load_use   = ex_is_load && ex_wr_nz && id_hits_ex;
        redirect   = ex_redirect || ex_jalr;
`ifdef PIPE_FWD_EN
        bubble     = load_use;
`else
        bubble     = load_use || (ex_wr_nz && id_hits_ex)
                   || (mem_wr_nz && ((id_use_rs1 && (id_rs1 == mem_rd))
                                  || (id_use_rs2 && (id_rs2 == mem_rd))));
`endif
        imem_ok    = (i_state_q == I_DONE) || imem_resp;
        dmem_ok    = !dmem_req || (d_state_q == D_DONE) || ((d_state_q == D_WAIT) && dmem_resp);
        adv        = !rst && imem_ok && dmem_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_state_q <= I_WAIT;
            d_state_q <= D_IDLE;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            i_state_q <= i_state_d;
            d_state_q <= d_state_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    // Next state: responses latch until the pipeline advances; counters saturate
    always_comb begin
        i_state_d = i_state_q;
        d_state_d = d_state_q;
        stall_d   = stall_q;
        flush_d   = flush_q;

        if (adv) begin
            i_state_d = I_WAIT;
        end else if ((i_state_q == I_WAIT) && imem_resp) begin
            i_state_d = I_DONE;
        end

        if (adv) begin
            d_state_d = D_IDLE;
        end else begin
            case (d_state_q)
                D_IDLE:  if (dmem_req) d_state_d = D_WAIT;
                D_WAIT:  if (dmem_resp) d_state_d = D_DONE;
                D_DONE:  d_state_d = D_DONE;
                default: d_state_d = D_IDLE;
            endcase
        end

        if ((!adv || (bubble && !redirect)) && (stall_q != '1)) begin
            stall_d = stall_q + PERF_W'(1);
        end
        if (adv && redirect && (flush_q != '1)) begin
            flush_d = flush_q + PERF_W'(1);
        end
    end

    // Outputs are all forced low while reset is asserted
    always_comb begin
        imem_read  = 1'b0;
        dmem_go    = 1'b0;
        advance    = 1'b0;
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pc_sel     = 2'd0;
        fwd_a_sel  = 2'd0;
        fwd_b_sel  = 2'd0;
        stall_cnt  = '0;
        flush_cnt  = '0;
        if (!rst) begin
            imem_read  = (i_state_q == I_WAIT);
            dmem_go    = (d_state_q == D_WAIT);
            advance    = adv;
            ifid_flush = redirect;
            idex_flush = redirect || bubble;
            pc_hold    = bubble && !redirect;
            ifid_hold  = bubble && !redirect;
            if (redirect) pc_sel = ex_jalr ? 2'd2 : 2'd1;
`ifdef PIPE_FWD_EN
            fwd_a_sel  = fwd_sel(ex_rs1, mem_wr_nz, mem_rd, wb_regwrite && (wb_rd != '0), wb_rd);
            fwd_b_sel  = fwd_sel(ex_rs2, mem_wr_nz, mem_rd, wb_regwrite && (wb_rd != '0), wb_rd);
`endif
            stall_cnt  = stall_q;
            flush_cnt  = flush_q;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned RW  = 5;
    localparam int unsigned PW  = 4;
    localparam int          CAP = (1 << PW) - 1;
`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic imem_resp, dmem_req, dmem_resp;
    logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_regwrite, mem_regwrite, wb_regwrite;
    logic ex_is_load, ex_redirect, ex_jalr;
    logic imem_read, dmem_go, advance, pc_hold, ifid_hold, ifid_flush, idex_flush;
    logic [1:0] pc_sel, fwd_a_sel, fwd_b_sel;
    logic [PW-1:0] stall_cnt, flush_cnt;
    logic [20:0] obs;

    int tests = 0;
    int failures = 0;

    // Model: has the fetch response arrived, is a data access in flight, has its data arrived
    bit m_ihave, m_dwait, m_dhave;
    int m_stall, m_flush;

    always #5 clk = ~clk;

    assign obs = {advance, imem_read, dmem_go, pc_hold, ifid_hold, ifid_flush, idex_flush,
                  pc_sel, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt};

    pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .imem_read(imem_read),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dmem_go(dmem_go),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .ex_jalr(ex_jalr),
        .advance(advance), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pc_sel(pc_sel),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic bit m_adv();
        return !rst && (m_ihave || imem_resp) && (!dmem_req || m_dhave || (m_dwait && dmem_resp));
    endfunction

    function automatic bit m_hazard();
        logic [RW-1:0] src [2];
        bit            used[2];
        bit            h = 1'b0;
        src[0] = id_rs1; src[1] = id_rs2;
        used[0] = id_use_rs1; used[1] = id_use_rs2;
        for (int i = 0; i < 2; i++) begin
            if (used[i] && src[i] != 0) begin
                if (ex_regwrite && src[i] == ex_rd && (ex_is_load || !FWD)) h = 1'b1;
                if (!FWD && mem_regwrite && src[i] == mem_rd) h = 1'b1;
            end
        end
        return h;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [RW-1:0] rs);
        if (!FWD || rs == 0) return 2'd0;
        if (mem_regwrite && mem_rd == rs) return 2'd1;
        if (wb_regwrite && wb_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [20:0] m_expect();
        bit redir = ex_redirect || ex_jalr;
        bit bub   = m_hazard();
        bit hold  = bub && !redir;
        logic [1:0] sel = redir ? (ex_jalr ? 2'd2 : 2'd1) : 2'd0;
        if (rst) return '0;
        return {m_adv(), !m_ihave, m_dwait, hold, hold, redir, redir || bub,
                sel, m_fwd(ex_rs1), m_fwd(ex_rs2), PW'(m_stall), PW'(m_flush)};
    endfunction

    // Advance the model with the inputs present at this edge, then clock the DUT
    task automatic cycle();
        bit a, redir, bub;
        if (rst) begin
            m_ihave = 0; m_dwait = 0; m_dhave = 0; m_stall = 0; m_flush = 0;
        end else begin
            a = m_adv();
            redir = ex_redirect || ex_jalr;
            bub = m_hazard();
            if ((!a || (bub && !redir)) && m_stall < CAP) m_stall++;
            if (a && redir && m_flush < CAP) m_flush++;
            if (a) begin
                m_ihave = 0; m_dwait = 0; m_dhave = 0;
            end else begin
                if (imem_resp) m_ihave = 1;
                if (m_dwait && dmem_resp) begin
                    m_dwait = 0; m_dhave = 1;
                end else if (!m_dwait && !m_dhave && dmem_req) begin
                    m_dwait = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0;
        ex_is_load = 0; ex_redirect = 0; ex_jalr = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        imem_resp = 1; ex_jalr = 1; ex_is_load = 1; ex_regwrite = 1; ex_rd = 3;
        id_rs1 = 3; id_use_rs1 = 1; mem_regwrite = 1; mem_rd = 4; ex_rs1 = 4;
        cycle();
        @(negedge clk);
        tests++;
        if (obs !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 000000", obs);
        end
        cycle();
        clear_inputs();
        rst = 0;
        @(negedge clk);
        tests++;
        if ({imem_read, dmem_go, advance, stall_cnt, flush_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_release: got ird=%b dgo=%b adv=%b stall=%0d flush=%0d expected 1 0 0 0 0",
                     imem_read, dmem_go, advance, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_imem_handshake();
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            imem_resp = (c == 3);
            @(negedge clk);
            tests++;
            if ({advance, imem_read} !== {c == 3, 1'b1}) begin
                failures++;
                $display("FAIL imem_cycle%0d: got adv=%b ird=%b expected adv=%b ird=1", c, advance, imem_read, c == 3);
            end
            cycle();
        end
        imem_resp = 0;
        @(negedge clk);
        tests++;
        if (stall_cnt !== 4'd3) begin
            failures++;
            $display("FAIL imem_stall_count: got %0d expected 3", stall_cnt);
        end
    endtask

    task automatic test_split_resp();
        do_reset();
        dmem_req = 1;
        for (int c = 1; c <= 7; c++) begin
            dmem_resp = (c == 2);
            imem_resp = (c == 5);
            @(negedge clk);
            tests++;
            if ({advance, dmem_go} !== {c == 5, (c == 2) || (c == 7)}) begin
                failures++;
                $display("FAIL split_cycle%0d: got adv=%b dgo=%b expected adv=%b dgo=%b",
                         c, advance, dmem_go, c == 5, (c == 2) || (c == 7));
            end
            cycle();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        imem_resp = 1;
        ex_is_load = 1; ex_regwrite = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        @(negedge clk);
        tests++;
        if ({advance, pc_hold, ifid_hold, ifid_flush, idex_flush, pc_sel} !== 7'b1110100) begin
            failures++;
            $display("FAIL load_use_bubble: got %b expected 1110100",
                     {advance, pc_hold, ifid_hold, ifid_flush, idex_flush, pc_sel});
        end
        cycle();
        ex_is_load = 0; ex_regwrite = 0; ex_rd = 0; mem_regwrite = 1; mem_rd = 5;
        @(negedge clk);
        tests++;
        if ({pc_hold, idex_flush} !== {!FWD, !FWD} || stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL load_use_after: got hold=%b idex=%b stall=%0d expected hold=%b idex=%b stall=1",
                     pc_hold, idex_flush, stall_cnt, !FWD, !FWD);
        end
        cycle();
        clear_inputs();
        imem_resp = 1; ex_is_load = 1; ex_regwrite = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 0;
        @(negedge clk);
        tests++;
        if ({pc_hold, idex_flush} !== 2'b00) begin
            failures++;
            $display("FAIL load_use_unused_src: got hold=%b idex=%b expected 0 0", pc_hold, idex_flush);
        end
        cycle();
        ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1; id_rs1 = 0; id_use_rs1 = 1;
        @(negedge clk);
        tests++;
        if ({pc_hold, idex_flush} !== 2'b00) begin
            failures++;
            $display("FAIL load_use_x0: got hold=%b idex=%b expected 0 0", pc_hold, idex_flush);
        end
        cycle();
        clear_inputs();
    endtask

    task automatic test_redirect();
        do_reset();
        imem_resp = 1;
        ex_is_load = 1; ex_regwrite = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; ex_jalr = 1;
        @(negedge clk);
        tests++;
        if ({pc_sel, pc_hold, ifid_hold, ifid_flush, idex_flush} !== 6'b100011) begin
            failures++;
            $display("FAIL redirect_jalr: got %b expected 100011",
                     {pc_sel, pc_hold, ifid_hold, ifid_flush, idex_flush});
        end
        cycle();
        clear_inputs();
        imem_resp = 1; ex_redirect = 1;
        @(negedge clk);
        tests++;
        if ({pc_sel, ifid_flush, idex_flush, flush_cnt} !== {2'd1, 2'b11, 4'd1}) begin
            failures++;
            $display("FAIL redirect_branch: got sel=%0d flush=%b%b cnt=%0d expected sel=1 flush=11 cnt=1",
                     pc_sel, ifid_flush, idex_flush, flush_cnt);
        end
        cycle();
        ex_redirect = 0;
        @(negedge clk);
        tests++;
        if ({pc_sel, ifid_flush, flush_cnt} !== {2'd0, 1'b0, 4'd2}) begin
            failures++;
            $display("FAIL redirect_count: got sel=%0d flush=%b cnt=%0d expected sel=0 flush=0 cnt=2",
                     pc_sel, ifid_flush, flush_cnt);
        end
        cycle();
        clear_inputs();
    endtask

    task automatic test_forwarding();
        do_reset();
        imem_resp = 1;
        mem_regwrite = 1; mem_rd = 7; wb_regwrite = 1; wb_rd = 7; ex_rs1 = 7; ex_rs2 = 7;
        @(negedge clk);
        tests++;
        if ({fwd_a_sel, fwd_b_sel} !== (FWD ? 4'b0101 : 4'b0000)) begin
            failures++;
            $display("FAIL fwd_mem_priority: got a=%0d b=%0d expected %0d", fwd_a_sel, fwd_b_sel, FWD ? 1 : 0);
        end
        cycle();
        mem_regwrite = 0;
        @(negedge clk);
        tests++;
        if ({fwd_a_sel, fwd_b_sel} !== (FWD ? 4'b1010 : 4'b0000)) begin
            failures++;
            $display("FAIL fwd_wb: got a=%0d b=%0d expected %0d", fwd_a_sel, fwd_b_sel, FWD ? 2 : 0);
        end
        cycle();
        mem_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        @(negedge clk);
        tests++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            failures++;
            $display("FAIL fwd_x0: got a=%0d b=%0d expected 0", fwd_a_sel, fwd_b_sel);
        end
        cycle();
        clear_inputs();
        imem_resp = 1; id_rs1 = 7; id_use_rs1 = 1; mem_rd = 7; mem_regwrite = 1;
        @(negedge clk);
        tests++;
        if ({pc_hold, ifid_hold, idex_flush} !== {3{!FWD}}) begin
            failures++;
            $display("FAIL raw_mem_stall: got %b expected %b", {pc_hold, ifid_hold, idex_flush}, {3{!FWD}});
        end
        cycle();
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int c = 0; c < 20; c++) cycle();
        @(negedge clk);
        tests++;
        if (stall_cnt !== 4'd15) begin
            failures++;
            $display("FAIL stall_saturate: got %0d expected 15", stall_cnt);
        end
        cycle();
        @(negedge clk);
        tests++;
        if (stall_cnt !== 4'd15) begin
            failures++;
            $display("FAIL stall_no_wrap: got %0d expected 15", stall_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        dmem_req = 1;
        cycle();
        @(negedge clk);
        tests++;
        if (dmem_go !== 1'b1) begin
            failures++;
            $display("FAIL mid_wait_go: got %b expected 1", dmem_go);
        end
        cycle();
        rst = 1; dmem_resp = 1;
        @(negedge clk);
        tests++;
        if (obs !== 21'd0) begin
            failures++;
            $display("FAIL mid_wait_reset_outputs: got %h expected 000000", obs);
        end
        cycle();
        rst = 0; dmem_req = 0; dmem_resp = 1;
        @(negedge clk);
        tests++;
        if (dmem_go !== 1'b0) begin
            failures++;
            $display("FAIL mid_wait_abandon: got dgo=%b expected 0", dmem_go);
        end
        cycle();
        dmem_req = 1; dmem_resp = 0; imem_resp = 1;
        @(negedge clk);
        tests++;
        if ({dmem_go, advance} !== 2'b00) begin
            failures++;
            $display("FAIL stray_resp_ignored: got dgo=%b adv=%b expected 0 0", dmem_go, advance);
        end
        cycle();
        dmem_resp = 1;
        @(negedge clk);
        tests++;
        if ({dmem_go, advance} !== 2'b11) begin
            failures++;
            $display("FAIL rewait_complete: got dgo=%b adv=%b expected 1 1", dmem_go, advance);
        end
        cycle();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [20:0] exp_v;
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            imem_resp    = ($urandom_range(0, 9) < 4);
            dmem_req     = ($urandom_range(0, 2) == 0);
            dmem_resp    = ($urandom_range(0, 9) < 3);
            id_rs1       = RW'($urandom_range(0, 3));
            id_rs2       = RW'($urandom_range(0, 3));
            ex_rs1       = RW'($urandom_range(0, 3));
            ex_rs2       = RW'($urandom_range(0, 3));
            ex_rd        = RW'($urandom_range(0, 3));
            mem_rd       = RW'($urandom_range(0, 3));
            wb_rd        = RW'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom);
            id_use_rs2   = 1'($urandom);
            ex_regwrite  = 1'($urandom);
            mem_regwrite = 1'($urandom);
            wb_regwrite  = 1'($urandom);
            ex_is_load   = ($urandom_range(0, 3) == 0);
            ex_redirect  = ($urandom_range(0, 9) == 0);
            ex_jalr      = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            exp_v = m_expect();
            tests++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random_cycle%0d: got %b expected %b", n, obs, exp_v);
            end
            cycle();
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_imem_handshake();
        test_split_resp();
        test_load_use();
        test_redirect();
        test_forwarding();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
